// File: rtl/vj_pyramid_pkg.sv
// Shared pyramid geometry: full-resolution frame size, per-level Q8.8 upscale
// factors and the detection record types exchanged between scanners and collector.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 640
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 480
`endif
`ifndef PYRAMID_LEVELS
`define PYRAMID_LEVELS 6
`endif

package vj_pyramid_pkg;

  localparam int IMG_W_FULL = `LAPTOP_WIDTH;
  localparam int IMG_H_FULL = `LAPTOP_HEIGHT;
  localparam int NUM_LEVELS = `PYRAMID_LEVELS;
  localparam int Q_ROUND    = 128;

  // round(256*640/w) for level widths 640, 512, 410, 328, 262, 210
  localparam logic [NUM_LEVELS-1:0][15:0] PYRAMID_SCALES_Q8 = {
    16'd780, 16'd625, 16'd500, 16'd400, 16'd320, 16'd256
  };

  typedef struct packed {
    logic [3:0] level;
    logic [7:0] x;
    logic [7:0] y;
  } det_in_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] size;
  } det_out_t;

  // Out-of-table levels return 0; callers drop those detections anyway.
  function automatic logic [15:0] level_scale(input logic [3:0] lvl);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl == 4'(i)) s = PYRAMID_SCALES_Q8[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/det_fifo.sv
// Small synchronous FIFO of mapped detections; head is visible combinationally.
module det_fifo
  import vj_pyramid_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  det_out_t      i_data,
  input  logic          i_pop,
  output det_out_t      o_head,
  output logic [CW-1:0] o_count
);

  det_out_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/detection_upmapper.sv
// Maps (level, x, y) face-window hits back to full-resolution coordinates and size
// through a two-stage multiply/round pipeline feeding a credit-controlled output FIFO.
module detection_upmapper
  import vj_pyramid_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_W_FULL,
  parameter int IMG_HEIGHT = IMG_H_FULL,
  parameter int LEVELS     = NUM_LEVELS,
  parameter int WIN_SIZE   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_level,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic [9:0]  out_size,
  output logic [15:0] det_count,
  output logic        level_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = CW + 1;
  localparam logic [4:0] LEVELS_W = 5'(LEVELS);

  det_in_t       w_in;
  logic          w_accept;
  logic          w_level_ok;
  logic [FW-1:0] w_in_flight;
  logic [CW-1:0] w_count;
  det_out_t      w_head;
  det_out_t      w_s2_next;
  logic [16:0]   w_px_q, w_py_q, w_ps_q;

  logic          r_s1_valid;
  logic [7:0]    r_s1_x;
  logic [7:0]    r_s1_y;
  logic [15:0]   r_s1_scale;
  logic          r_s2_valid;
  det_out_t      r_s2;
  logic [15:0]   r_det_count;
  logic          r_level_err;

  assign w_in       = '{level: in_level, x: in_x, y: in_y};
  assign w_accept   = in_valid && in_ready;
  assign w_level_ok = {1'b0, w_in.level} < LEVELS_W;

  // Credits cover every detection already accepted, so the FIFO can never overflow.
  assign w_in_flight = FW'(r_s1_valid) + FW'(r_s2_valid) + FW'(w_count);
  assign in_ready    = w_in_flight < FW'(FIFO_DEPTH);

  assign w_px_q = 17'((25'(r_s1_x) * 25'(r_s1_scale) + 25'(Q_ROUND)) >> 8);
  assign w_py_q = 17'((25'(r_s1_y) * 25'(r_s1_scale) + 25'(Q_ROUND)) >> 8);
  assign w_ps_q = 17'((25'(WIN_SIZE) * 25'(r_s1_scale) + 25'(Q_ROUND)) >> 8);

  always_comb begin
    w_s2_next.x    = (w_px_q > 17'(IMG_WIDTH - 1))  ? 10'(IMG_WIDTH - 1)  : w_px_q[9:0];
    w_s2_next.y    = (w_py_q > 17'(IMG_HEIGHT - 1)) ? 10'(IMG_HEIGHT - 1) : w_py_q[9:0];
    w_s2_next.size = (w_ps_q > 17'd1023)            ? 10'd1023            : w_ps_q[9:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_scale  <= '0;
      r_s2_valid  <= 1'b0;
      r_s2        <= '0;
      r_det_count <= '0;
      r_level_err <= 1'b0;
    end else begin
      r_s1_valid <= w_accept && w_level_ok;
      if (w_accept && w_level_ok) begin
        r_s1_x     <= w_in.x;
        r_s1_y     <= w_in.y;
        r_s1_scale <= level_scale(w_in.level);
      end
      if (w_accept && !w_level_ok) r_level_err <= 1'b1;

      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_s2 <= w_s2_next;

      if (out_valid && out_ready && (r_det_count != 16'hFFFF))
        r_det_count <= r_det_count + 16'd1;
    end
  end

  det_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_s2_valid),
    .i_data  (r_s2),
    .i_pop   (out_ready),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_valid = (w_count != '0);
  assign out_x     = w_head.x;
  assign out_y     = w_head.y;
  assign out_size  = w_head.size;
  assign det_count = r_det_count;
  assign level_err = r_level_err;

endmodule

// File: tb/tb_detection_upmapper.sv
// Randomized bench for detection_upmapper against a queue-based reference model;
// a second instance with a 12-pixel frame width exercises x clamping in lockstep.
module tb_detection_upmapper;

  localparam int LEVELS = 6;
  localparam int FULL_W = 640;
  localparam int FULL_H = 480;
  localparam int SAT_W  = 12;
  localparam int DEPTH  = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  in_level = '0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;

  logic        in_ready, out_valid, level_err;
  logic [9:0]  out_x, out_y, out_size;
  logic [15:0] det_count;

  logic        s_in_ready, s_out_valid, s_level_err;
  logic [9:0]  s_out_x, s_out_y, s_out_size;
  logic [15:0] s_det_count;

  always #5 clock = ~clock;

  detection_upmapper #(
    .IMG_WIDTH(FULL_W), .IMG_HEIGHT(FULL_H), .LEVELS(LEVELS), .WIN_SIZE(24), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_level(in_level), .in_x(in_x), .in_y(in_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_size(out_size),
    .det_count(det_count), .level_err(level_err)
  );

  detection_upmapper #(
    .IMG_WIDTH(SAT_W), .IMG_HEIGHT(FULL_H), .LEVELS(LEVELS), .WIN_SIZE(24), .FIFO_DEPTH(DEPTH)
  ) dut_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_level(in_level), .in_x(in_x), .in_y(in_y), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_x(s_out_x), .out_y(s_out_y), .out_size(s_out_size),
    .det_count(s_det_count), .level_err(s_level_err)
  );

  typedef struct {
    int x;
    int y;
    int size;
    int sx;
    int rdy;
  } exp_t;

  exp_t q[$];
  int   widths[LEVELS] = '{640, 512, 410, 328, 262, 210};
  int   scl[LEVELS];
  int   cyc = 0;
  int   m_cnt = 0;
  bit   m_err = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t map_det(input int lvl, input int x, input int y);
    exp_t e;
    int   s;
    s      = scl[lvl];
    e.x    = (x * s + 128) / 256;
    e.y    = (y * s + 128) / 256;
    e.size = (24 * s + 128) / 256;
    e.sx   = (e.x > SAT_W - 1) ? SAT_W - 1 : e.x;
    if (e.x > FULL_W - 1) e.x = FULL_W - 1;
    if (e.y > FULL_H - 1) e.y = FULL_H - 1;
    if (e.size > 1023) e.size = 1023;
    e.rdy = 0;
    return e;
  endfunction

  task automatic check_outputs();
    bit v;
    v = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_valid", out_valid, v);
    chk("det_count", det_count, m_cnt);
    chk("level_err", level_err, m_err);
    chk("sat_out_valid", s_out_valid, v);
    if (v) begin
      chk("out_x", out_x, q[0].x);
      chk("out_y", out_y, q[0].y);
      chk("out_size", out_size, q[0].size);
      chk("sat_out_x", s_out_x, q[0].sx);
      chk("sat_out_y", s_out_y, q[0].y);
    end
  endtask

  task automatic step(input bit iv, input int lvl, input int x, input int y, input bit ordy);
    bit   acc;
    bit   pop;
    exp_t e;
    check_outputs();
    in_valid  = iv;
    in_level  = 4'(lvl);
    in_x      = 8'(x);
    in_y      = 8'(y);
    out_ready = ordy;
    acc = iv && (q.size() < DEPTH);
    pop = (q.size() > 0) && (q[0].rdy <= cyc) && ordy;
    @(posedge clock);
    cyc++;
    if (pop) begin
      void'(q.pop_front());
      if (m_cnt < 65535) m_cnt++;
    end
    if (acc) begin
      if (lvl >= LEVELS) m_err = 1'b1;
      else begin
        e     = map_det(lvl, x, y);
        e.rdy = cyc + 2;
        q.push_back(e);
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < LEVELS; i++)
      scl[i] = $rtoi(256.0 * real'(FULL_W) / real'(widths[i]) + 0.5);

    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_det_count", det_count, 0);
    chk("rst_level_err", level_err, 0);
    reset = 1'b0;
    @(negedge clock);

    idle(2);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // identity level
    step(1'b1, 0, 40, 30, 1'b1);
    idle(2);
    chk("l0_valid", out_valid, 1);
    chk("l0_x", out_x, 40);
    chk("l0_y", out_y, 30);
    chk("l0_size", out_size, 24);
    idle(1);
    chk("l0_count", det_count, 1);

    // scale 320, plus clamping on the narrow instance
    step(1'b1, 1, 10, 7, 1'b1);
    idle(2);
    chk("l1_x", out_x, 13);
    chk("l1_y", out_y, 9);
    chk("l1_size", out_size, 30);
    chk("sat_x", s_out_x, 11);
    idle(1);

    // backpressure: only FIFO_DEPTH credits available
    for (int i = 0; i < 6; i++) step(1'b1, 1, (i + 1) * 20, (i + 1) * 10, 1'b0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head_x", out_x, 25);
    step(1'b0, 0, 0, 0, 1'b1);
    chk("bp_ready_back", in_ready, 1);
    idle(5);
    chk("bp_count", det_count, 6);

    // out-of-range level is dropped and sticks in level_err
    step(1'b1, LEVELS, 5, 5, 1'b1);
    idle(1);
    chk("lerr_set", level_err, 1);
    idle(3);
    chk("lerr_hold", level_err, 1);
    chk("lerr_no_out", out_valid, 0);
    step(1'b1, 2, 100, 50, 1'b1);
    idle(2);
    chk("l2_x", out_x, 156);
    chk("l2_y", out_y, 78);
    chk("l2_size", out_size, 38);
    idle(1);

    repeat (400)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 9) < 7);

    // reset in the middle of a burst
    for (int i = 0; i < 5; i++)
      step(1'b1, $urandom_range(0, LEVELS - 1), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0);
    chk("pre_rst_level_err", level_err, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_level_err", level_err, 0);
    chk("mid_rst_det_count", det_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_x", out_x, 0);
    q.delete();
    m_cnt    = 0;
    m_err    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle(6);

    repeat (60)
      step($urandom_range(0, 1) != 0, $urandom_range(0, 6), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 3) != 0);
    idle(8);
    check_outputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
